// File: rtl/decrementer_timer.sv
`default_nettype none
// ============================================================================
//  Module   : decrementer_timer
//  Purpose  : Loadable down-counter with an IDLE/RUN control FSM. In RUN it
//             counts down while en is high and pulses done on reaching zero
//             (optionally reloading). In IDLE, step performs a single modulo
//             decrement and pulses bout on a 0 -> all-ones wrap.
//  Revision : 1.0  initial release
// ============================================================================
module decrementer_timer #(
   parameter int WIDTH       = 4,
   parameter int AUTO_RELOAD = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   input  logic             en,
   input  logic             step,
   output logic [WIDTH-1:0] q,
   output logic             busy,
   output logic             done,
   output logic             bout,
   output logic             zero
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic [WIDTH-1:0] c_zero = '0;
   localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] w_q_nxt;
   logic [WIDTH-1:0] r_reload;
   logic [WIDTH-1:0] w_reload_nxt;
   logic             r_done;
   logic             w_done_nxt;
   logic             r_bout;
   logic             w_bout_nxt;
   logic [WIDTH-1:0] w_q_dec;

   // Modulo-2^WIDTH decrement shared by the RUN countdown and IDLE step.
   assign w_q_dec = r_q - c_one;

   // FSM state register; reset aborts any count in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and datapath decode; load takes priority in every state.
   always_comb begin
      w_state_nxt  = r_state;
      w_q_nxt      = r_q;
      w_reload_nxt = r_reload;
      w_done_nxt   = 1'b0;
      w_bout_nxt   = 1'b0;
      if (load) begin
         // A zero load parks the timer in IDLE without ever signalling done.
         w_q_nxt      = din;
         w_reload_nxt = din;
         w_state_nxt  = (din != c_zero) ? ST_RUN : ST_IDLE;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (en) begin
                  if (r_q == c_zero) begin
                     // Only reachable with auto-reload: restart from the
                     // last loaded value after the zero cycle.
                     w_q_nxt = r_reload;
                  end else begin
                     w_q_nxt = w_q_dec;
                     if (r_q == c_one) begin
                        w_done_nxt = 1'b1;
                        if (AUTO_RELOAD == 0) begin
                           w_state_nxt = ST_IDLE;
                        end
                     end
                  end
               end
            end
            ST_IDLE: begin
               if (step) begin
                  w_q_nxt    = w_q_dec;
                  w_bout_nxt = (r_q == c_zero);
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // Count, reload value and registered event pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q      <= c_zero;
         r_reload <= c_zero;
         r_done   <= 1'b0;
         r_bout   <= 1'b0;
      end else begin
         r_q      <= w_q_nxt;
         r_reload <= w_reload_nxt;
         r_done   <= w_done_nxt;
         r_bout   <= w_bout_nxt;
      end
   end

   assign q    = r_q;
   assign busy = (r_state == ST_RUN);
   assign done = r_done;
   assign bout = r_bout;
   assign zero = (r_q == c_zero);

endmodule
`default_nettype wire

// File: tb/tb_decrementer_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decrementer_timer
//  Purpose  : Self-checking bench for decrementer_timer (WIDTH=4), one
//             instance without and one with auto-reload, driven in lockstep.
//  Revision : 1.0  initial release
// ============================================================================
module tb_decrementer_timer;

   logic       clk;
   logic       rst_n;
   logic       load;
   logic [3:0] din;
   logic       en;
   logic       step;

   logic [3:0] q0, q1;
   logic       busy0, busy1, done0, done1, bout0, bout1, zero0, zero1;

   int n_pass;
   int n_total;

   decrementer_timer #(.WIDTH(4), .AUTO_RELOAD(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .load(load), .din(din), .en(en), .step(step),
      .q(q0), .busy(busy0), .done(done0), .bout(bout0), .zero(zero0)
   );

   decrementer_timer #(.WIDTH(4), .AUTO_RELOAD(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .load(load), .din(din), .en(en), .step(step),
      .q(q1), .busy(busy1), .done(done1), .bout(bout1), .zero(zero1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural reference: index 0 = no auto-reload, index 1 = auto-reload.
   int m_cnt  [2];
   int m_rel  [2];
   bit m_run  [2];
   bit m_done [2];
   bit m_bout [2];

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_cnt[i] = 0; m_rel[i] = 0; m_run[i] = 0; m_done[i] = 0; m_bout[i] = 0;
      end
   endtask

   task automatic model_edge();
      for (int i = 0; i < 2; i++) begin
         m_done[i] = 0;
         m_bout[i] = 0;
         if (load) begin
            m_cnt[i] = int'(din);
            m_rel[i] = int'(din);
            m_run[i] = (din != 0);
         end else if (m_run[i]) begin
            if (en) begin
               if (m_cnt[i] == 0) begin
                  m_cnt[i] = m_rel[i];
               end else begin
                  m_cnt[i] = m_cnt[i] - 1;
                  if (m_cnt[i] == 0) begin
                     m_done[i] = 1;
                     if (i == 0) m_run[i] = 0;
                  end
               end
            end
         end else if (step) begin
            m_bout[i] = (m_cnt[i] == 0);
            m_cnt[i]  = (m_cnt[i] + 15) % 16;
         end
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   task automatic chk_model();
      chk("m_q0",    32'(q0),    32'(m_cnt[0]));
      chk("m_busy0", 32'(busy0), 32'(m_run[0]));
      chk("m_done0", 32'(done0), 32'(m_done[0]));
      chk("m_bout0", 32'(bout0), 32'(m_bout[0]));
      chk("m_zero0", 32'(zero0), 32'(m_cnt[0] == 0));
      chk("m_q1",    32'(q1),    32'(m_cnt[1]));
      chk("m_busy1", 32'(busy1), 32'(m_run[1]));
      chk("m_done1", 32'(done1), 32'(m_done[1]));
      chk("m_bout1", 32'(bout1), 32'(m_bout[1]));
      chk("m_zero1", 32'(zero1), 32'(m_cnt[1] == 0));
   endtask

   // One clock: advance the model at the edge, then sample 1 time unit later.
   task automatic cycle();
      @(posedge clk);
      if (rst_n) model_edge();
      #1;
      chk_model();
   endtask

   typedef struct {
      logic       load;
      logic [3:0] din;
      logic       en;
      logic       step;
      logic [3:0] eq;
      logic       eb;
      logic       ed;
      logic       ebo;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic l, input logic [3:0] d, input logic e,
                               input logic s, input logic [3:0] xq, input logic xb,
                               input logic xd, input logic xbo);
      vec_t v;
      v.load = l; v.din = d; v.en = e; v.step = s;
      v.eq = xq; v.eb = xb; v.ed = xd; v.ebo = xbo;
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] ar_q [6];
      logic       ar_d [6];
      n_pass = 0; n_total = 0;
      rst_n = 1'b0; load = 1'b0; din = 4'd0; en = 1'b0; step = 1'b0;
      model_reset();

      // Countdown 3,2,1,0 with done only at 0; IDLE ignores en; step wraps.
      tbl.push_back(mk(1, 4'd3, 1, 0, 4'd3,  1, 0, 0));
      tbl.push_back(mk(0, 4'd0, 1, 0, 4'd2,  1, 0, 0));
      tbl.push_back(mk(0, 4'd0, 1, 0, 4'd1,  1, 0, 0));
      tbl.push_back(mk(0, 4'd0, 1, 0, 4'd0,  0, 1, 0));
      tbl.push_back(mk(0, 4'd0, 1, 0, 4'd0,  0, 0, 0));
      tbl.push_back(mk(0, 4'd0, 0, 1, 4'd15, 0, 0, 1));
      tbl.push_back(mk(0, 4'd0, 0, 1, 4'd14, 0, 0, 0));
      tbl.push_back(mk(0, 4'd0, 1, 0, 4'd14, 0, 0, 0));
      // Pause at 5 with step asserted, then resume.
      tbl.push_back(mk(1, 4'd6, 1, 0, 4'd6,  1, 0, 0));
      tbl.push_back(mk(0, 4'd0, 1, 0, 4'd5,  1, 0, 0));
      for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 4'd0, 0, 1, 4'd5, 1, 0, 0));
      tbl.push_back(mk(0, 4'd0, 1, 0, 4'd4,  1, 0, 0));
      tbl.push_back(mk(0, 4'd0, 1, 0, 4'd3,  1, 0, 0));
      tbl.push_back(mk(0, 4'd0, 1, 0, 4'd2,  1, 0, 0));
      tbl.push_back(mk(0, 4'd0, 1, 0, 4'd1,  1, 0, 0));
      // Load on the terminal edge wins; then a zero load.
      tbl.push_back(mk(1, 4'd9, 1, 0, 4'd9,  1, 0, 0));
      tbl.push_back(mk(1, 4'd0, 1, 0, 4'd0,  0, 0, 0));
      tbl.push_back(mk(0, 4'd0, 1, 0, 4'd0,  0, 0, 0));
      tbl.push_back(mk(0, 4'd0, 0, 1, 4'd15, 0, 0, 1));

      // Reset state while rst_n is held low.
      #12;
      chk("rst_q0", 32'(q0), 32'd0);
      chk("rst_busy0", 32'(busy0), 32'd0);
      chk("rst_done0", 32'(done0), 32'd0);
      chk("rst_bout0", 32'(bout0), 32'd0);
      chk("rst_zero0", 32'(zero0), 32'd1);
      chk("rst_zero1", 32'(zero1), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         load = tbl[i].load; din = tbl[i].din; en = tbl[i].en; step = tbl[i].step;
         cycle();
         chk($sformatf("tbl%0d_q", i),    32'(q0),    32'(tbl[i].eq));
         chk($sformatf("tbl%0d_busy", i), 32'(busy0), 32'(tbl[i].eb));
         chk($sformatf("tbl%0d_done", i), 32'(done0), 32'(tbl[i].ed));
         chk($sformatf("tbl%0d_bout", i), 32'(bout0), 32'(tbl[i].ebo));
         chk($sformatf("tbl%0d_zero", i), 32'(zero0), 32'(tbl[i].eq == 4'd0));
      end

      // Auto-reload instance: load 2 -> 2,1,0,2,1,0 with done at each 0.
      ar_q = '{4'd2, 4'd1, 4'd0, 4'd2, 4'd1, 4'd0};
      ar_d = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      load = 1'b1; din = 4'd2; en = 1'b1; step = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cycle();
         load = 1'b0;
         chk($sformatf("ar%0d_q", i),    32'(q1),    32'(ar_q[i]));
         chk($sformatf("ar%0d_done", i), 32'(done1), 32'(ar_d[i]));
         chk($sformatf("ar%0d_busy", i), 32'(busy1), 32'd1);
      end

      // Asynchronous reset in the middle of a count.
      load = 1'b1; din = 4'd7; en = 1'b1;
      cycle();
      load = 1'b0;
      cycle();
      chk("pre_rst_q0", 32'(q0), 32'd6);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("arst_q0",    32'(q0),    32'd0);
      chk("arst_busy0", 32'(busy0), 32'd0);
      chk("arst_zero0", 32'(zero0), 32'd1);
      chk("arst_q1",    32'(q1),    32'd0);
      chk("arst_busy1", 32'(busy1), 32'd0);
      cycle();
      cycle();
      chk("arst_hold_done0", 32'(done0), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      load = 1'b1; din = 4'd5;
      cycle();
      chk("post_rst_q0", 32'(q0), 32'd5);
      chk("post_rst_busy0", 32'(busy0), 32'd1);
      load = 1'b0;

      // Randomised traffic against the reference model.
      for (int i = 0; i < 400; i++) begin
         load = ($urandom_range(0, 7) == 0);
         din  = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 5) == 0) din = 4'd0;
         en   = ($urandom_range(0, 3) != 0);
         step = $urandom_range(0, 1) == 1;
         cycle();
         chk("rnd_excl0", 32'(done0 & bout0), 32'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/decrementer_timer.md
DECREMENTER_TIMER -- requirements
Module: decrementer_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter width in bits (legal range 2..16).
REQ-002 SHALL have parameter AUTO_RELOAD, default 0; when 1, the counter reloads its last loaded value when it reaches zero.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port load  input  1  capture din into counter and reload register.
REQ-006 SHALL have port din  input  WIDTH  load value.
REQ-007 SHALL have port en  input  1  count-down enable while RUN.
REQ-008 SHALL have port step  input  1  single modulo decrement request while IDLE.
REQ-009 SHALL have port q  output  WIDTH  current count, registered.
REQ-010 SHALL have port busy  output  1  high while in RUN.
REQ-011 SHALL have port done  output  1  one-cycle pulse on reaching zero in RUN.
REQ-012 SHALL have port bout  output  1  one-cycle borrow pulse on a step wrap from 0 to all-ones.
REQ-013 SHALL have port zero  output  1  combinational decode (q == 0).

Function
REQ-014 SHALL implement a two-state FSM: IDLE and RUN; busy = (state == RUN).
REQ-015 SHALL give load priority over en and step, in every state.
REQ-016 On load with din != 0: q <= din, reload register <= din, state <= RUN on the next edge.
REQ-017 On load with din == 0: q <= 0, reload register <= 0, state <= IDLE, no done pulse.
REQ-018 In RUN, en=1, q > 1: q <= q - 1; state stays RUN.
REQ-019 In RUN, en=1, q == 1, AUTO_RELOAD=0: q <= 0, state <= IDLE, done = 1 in the same cycle q shows 0.
REQ-020 In RUN, en=1, q == 1, AUTO_RELOAD=1: q <= 0, state stays RUN, done = 1 for that cycle; on the next enabled edge q <= reload register.
REQ-021 In RUN, en=0: q, state and reload register hold; done and bout stay 0.
REQ-022 SHALL ignore step while in RUN.
REQ-023 In IDLE, step=1: q <= (q - 1) mod 2^WIDTH; bout <= 1 for one cycle if q was 0, else 0; state stays IDLE.
REQ-024 In IDLE, en has no effect.
REQ-025 SHALL register done and bout; each SHALL be high for exactly one cycle per event and never high at the same time.
REQ-026 On load coincident with the terminal decrement, the load wins: no done pulse, q <= din.
REQ-027 Latency: q reflects a load, step or enabled decrement one clock after the triggering edge.
REQ-028 Arithmetic is unsigned, modulo 2^WIDTH; no other wrap path exists.

Reset
REQ-029 rst_n low SHALL immediately force q=0, reload register=0, state=IDLE, busy=0, done=0 and bout=0, independent of clk.
REQ-030 Reset asserted mid-RUN SHALL abort the count with no done pulse; after reset, the block SHALL be ready to load on the first rising edge after rst_n rises.
REQ-031 zero SHALL read 1 during and after reset until q changes.

Verification
REQ-032 Reset, then load din=3 with en held high -> q goes 3,2,1,0 on successive cycles; done high only in the q=0 cycle; busy low after that cycle.
REQ-033 IDLE with q=0, pulse step once -> q=15 (WIDTH=4), bout high for 1 cycle; a second step -> q=14, bout=0.
REQ-034 AUTO_RELOAD=1, load 2, en high -> q sequence 2,1,0,2,1,0; done pulses at each 0; busy stays 1.
REQ-035 RUN at q=5, drop en for 4 cycles -> q holds 5; assert step meanwhile -> no change; resume en -> q=4 next cycle.
REQ-036 Load 9 at the same edge q goes 1->0 -> q=9, done stays 0; then assert rst_n=0 between clock edges -> q=0 and busy=0 immediately.
REQ-037 Load din=0 -> q=0, busy=0, zero=1, done never asserted.
